// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg
// Shared types and constants for the RV32I instruction encoder.
//   encoding_type    : R/I/S/B/U/J format select
//   instruction_type : one 32-bit RV32I instruction word
//   state_type       : encoder sequencing states
//   OPC_LUI / OPC_OP_IMM : opcodes used by the LI expansion
//   is_sext()        : true when a word is the sign extension of bit msb
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        ENC_R = 3'd0,
        ENC_I = 3'd1,
        ENC_S = 3'd2,
        ENC_B = 3'd3,
        ENC_U = 3'd4,
        ENC_J = 3'd5
    } encoding_type;

    typedef logic [31:0] instruction_type;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_EMIT2 = 1'b1
    } state_type;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;

    // Every bit from msb upward must equal bit msb, i.e. the masked
    // region is either all zeros or all ones.
    function automatic logic is_sext(input logic [31:0] value, input int unsigned msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((value & mask) == 32'h0) || ((value & mask) == mask);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if
// Request and output handshake bundle for inst_encoder.
//   req_*  : request side (valid/ready, format, LI flag, fields, immediate)
//   out_*  : registered output side (valid/ready, word, last, err)
// Modports: master = request producer / word consumer, slave = encoder.
interface inst_encoder_if;
    import inst_encoder_pkg::*;

    logic            req_valid;
    logic            req_ready;
    encoding_type    req_encoding;
    logic            req_li;
    logic [6:0]      req_opcode;
    logic [2:0]      req_funct3;
    logic [6:0]      req_funct7;
    logic [4:0]      req_rd;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [31:0]     req_imm;

    logic            out_valid;
    logic            out_ready;
    instruction_type out_instruction;
    logic            out_last;
    logic            out_err;

    modport master (
        output req_valid, req_encoding, req_li, req_opcode, req_funct3,
               req_funct7, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instruction, out_last, out_err
    );

    modport slave (
        input  req_valid, req_encoding, req_li, req_opcode, req_funct3,
               req_funct7, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instruction, out_last, out_err
    );

endinterface

// File: rtl/inst_encoder_pack.sv
// inst_pack
// Purely combinational packer: scatters operand fields and a 32-bit
// immediate into an RV32I word for the selected format. Immediate bits
// that the format cannot carry are dropped.
//   encoding         in  format select
//   opcode/funct3/funct7/rd/rs1/rs2  in  instruction fields
//   imm              in  immediate (byte offset for B/J)
//   word             out packed instruction
module inst_pack
    import inst_encoder_pkg::*;
(
    input  encoding_type    encoding,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [31:0]     imm,
    output instruction_type word
);

    // B and J scramble the immediate so that the sign bit always sits in
    // bit 31 of the instruction.
    always_comb begin
        word = '0;
        case (encoding)
            ENC_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            ENC_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            ENC_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            ENC_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            ENC_U: word = {imm[31:12], rd, opcode};
            ENC_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
// Packs request fields into RV32I words and expands the LI pseudo
// instruction into ADDI or LUI[/ADDI]. Words leave through a registered
// valid/ready port; a two-word LI holds off new requests until its
// second word has been loaded.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of inst_encoder_if (request + output handshake)
// Optional build macro: IMM_RANGE_CHECK_EN enables out_err, flagging
// immediates the selected format cannot represent.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    inst_encoder_if.slave bus
);

    state_type       state;
    state_type       next_state;
    logic            req_ready;
    logic            accept;
    logic            out_fire;

    logic            out_valid_q;
    logic            out_last_q;
    logic            out_err_q;
    instruction_type out_instruction_q;
    instruction_type second_word_q;

    logic            imm_fits12;
    logic [19:0]     li_hi;
    logic            two_word;

    encoding_type    first_enc;
    logic [6:0]      first_opcode;
    logic [2:0]      first_funct3;
    logic [6:0]      first_funct7;
    logic [4:0]      first_rs1;
    logic [4:0]      first_rs2;
    logic [31:0]     first_imm;
    instruction_type first_word;
    instruction_type second_word;
    logic            first_last;
    logic            first_err;

    assign req_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.req_valid && req_ready;
    assign out_fire  = out_valid_q && bus.out_ready;

    // The +0x800 rounding compensates for ADDI sign-extending its 12-bit
    // immediate; adding bit 11 to the upper 20 bits is the same thing.
    assign imm_fits12 = is_sext(bus.req_imm, 11);
    assign li_hi      = bus.req_imm[31:12] + {19'd0, bus.req_imm[11]};
    assign two_word   = bus.req_li && !imm_fits12 && (bus.req_imm[11:0] != 12'd0);
    assign first_last = !two_word;

    // LI overrides the caller's format and fields: either ADDI rd,x0,imm
    // when the value fits in 12 bits, or LUI rd,hi otherwise.
    always_comb begin
        first_enc    = bus.req_encoding;
        first_opcode = bus.req_opcode;
        first_funct3 = bus.req_funct3;
        first_funct7 = bus.req_funct7;
        first_rs1    = bus.req_rs1;
        first_rs2    = bus.req_rs2;
        first_imm    = bus.req_imm;
        if (bus.req_li) begin
            first_funct3 = 3'd0;
            first_funct7 = 7'd0;
            first_rs1    = 5'd0;
            first_rs2    = 5'd0;
            if (imm_fits12) begin
                first_enc    = ENC_I;
                first_opcode = OPC_OP_IMM;
            end else begin
                first_enc    = ENC_U;
                first_opcode = OPC_LUI;
                first_imm    = {li_hi, 12'd0};
            end
        end
    end

    inst_pack u_first_pack (
        .encoding (first_enc),
        .opcode   (first_opcode),
        .funct3   (first_funct3),
        .funct7   (first_funct7),
        .rd       (bus.req_rd),
        .rs1      (first_rs1),
        .rs2      (first_rs2),
        .imm      (first_imm),
        .word     (first_word)
    );

    // Second LI word is always ADDI rd,rd,imm[11:0]; it is only latched
    // when the request actually needs it.
    inst_pack u_second_pack (
        .encoding (ENC_I),
        .opcode   (OPC_OP_IMM),
        .funct3   (3'd0),
        .funct7   (7'd0),
        .rd       (bus.req_rd),
        .rs1      (bus.req_rd),
        .rs2      (5'd0),
        .imm      (bus.req_imm),
        .word     (second_word)
    );

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates the format would silently truncate; the word is
    // still emitted. R and LI requests are never flagged.
    always_comb begin
        first_err = 1'b0;
        if (!bus.req_li) begin
            case (bus.req_encoding)
                ENC_I, ENC_S: first_err = !is_sext(bus.req_imm, 11);
                ENC_B:        first_err = !is_sext(bus.req_imm, 12) || bus.req_imm[0];
                ENC_J:        first_err = !is_sext(bus.req_imm, 20) || bus.req_imm[0];
                ENC_U:        first_err = (bus.req_imm[11:0] != 12'd0);
                default:      first_err = 1'b0;
            endcase
        end
    end
`else
    assign first_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // EMIT2 is left as soon as the first LI word is taken, since the
    // second word moves into the output register on that same edge.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept && two_word) next_state = ST_EMIT2;
            ST_EMIT2: if (out_fire)           next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output register: a new request may replace a word in the same cycle
    // it transfers, which gives one word per cycle for single-word traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q       <= 1'b0;
            out_instruction_q <= '0;
            out_last_q        <= 1'b0;
            out_err_q         <= 1'b0;
            second_word_q     <= '0;
        end else if (accept) begin
            out_valid_q       <= 1'b1;
            out_instruction_q <= first_word;
            out_last_q        <= first_last;
            out_err_q         <= first_err;
            if (two_word) begin
                second_word_q <= second_word;
            end
        end else if (out_fire) begin
            if (state == ST_EMIT2) begin
                out_instruction_q <= second_word_q;
                out_last_q        <= 1'b1;
                out_err_q         <= 1'b0;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready       = req_ready;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_instruction = out_instruction_q;
    assign bus.out_last        = out_last_q;
    assign bus.out_err         = out_err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
// Self-checking bench for inst_encoder: directed cases for reset, the
// example encodings, LI expansion, stalls and mid-sequence reset, plus a
// randomized run against a reference model built from the RV32I format
// rules. Honours IMM_RANGE_CHECK_EN when it is defined for the build.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic        err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    inst_encoder_if bus ();

    inst_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input logic li, input encoding_type enc, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bus.req_li       = li;
        bus.req_encoding = enc;
        bus.req_opcode   = op;
        bus.req_funct3   = f3;
        bus.req_funct7   = f7;
        bus.req_rd       = rd;
        bus.req_rs1      = rs1;
        bus.req_rs2      = rs2;
        bus.req_imm      = imm;
    endtask

    // Field placement of each RV32I format.
    function automatic logic [31:0] model_word(input encoding_type enc, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [31:0] imm);
        case (enc)
            ENC_R:   return {f7, rs2, rs1, f3, rd, op};
            ENC_I:   return {imm[11:0], rs1, f3, rd, op};
            ENC_S:   return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            ENC_B:   return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            ENC_U:   return {imm[31:12], rd, op};
            ENC_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: return 32'h0;
        endcase
    endfunction

    // Representability as signed ranges and alignment.
    function automatic logic model_err(input logic li, input encoding_type enc, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
        longint s;
        s = longint'($signed(imm));
        if (li) return 1'b0;
        case (enc)
            ENC_I, ENC_S: return (s < -2048) || (s > 2047);
            ENC_B:        return (s < -4096) || (s > 4095) || (imm % 2 != 0);
            ENC_J:        return (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
            ENC_U:        return (imm % 4096) != 0;
            default:      return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_push(input logic li, input encoding_type enc, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        longint      s;
        logic [31:0] hi;
        logic [31:0] lo;
        exp_t        e;
        if (!li) begin
            e.word = model_word(enc, op, f3, f7, rd, rs1, rs2, imm);
            e.last = 1'b1;
            e.err  = model_err(1'b0, enc, imm);
            exp_q.push_back(e);
        end else begin
            s = longint'($signed(imm));
            if (s >= -2048 && s <= 2047) begin
                e.word = model_word(ENC_I, 7'h13, 3'd0, 7'd0, rd, 5'd0, 5'd0, imm);
                e.last = 1'b1;
                e.err  = 1'b0;
                exp_q.push_back(e);
            end else begin
                hi = (imm + 32'h800) / 4096;
                lo = imm % 4096;
                e.word = hi * 4096 + 32'(rd) * 128 + 32'h37;
                e.last = (lo == 0);
                e.err  = 1'b0;
                exp_q.push_back(e);
                if (lo != 0) begin
                    e.word = model_word(ENC_I, 7'h13, 3'd0, 7'd0, rd, rd, 5'd0, imm);
                    e.last = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_req(1'b0, ENC_R, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++;
        if (bus.out_instruction !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h want 0", bus.out_instruction); end
        n_checks++;
        if (bus.out_last !== 1'b0 || bus.out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last_err: got %b%b want 00", bus.out_last, bus.out_err); end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", bus.req_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        @(negedge clk);
        set_req(1'b0, ENC_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        bus.req_valid = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_pre: ready=%b valid=%b want 1/0", bus.req_ready, bus.out_valid); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_latency: valid=%b want 1", bus.out_valid); end
        n_checks++;
        if (bus.out_instruction !== 32'hFFF0_0093 || bus.out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_word: got %h last %b want fff00093 last 1", bus.out_instruction, bus.out_last); end
        @(negedge clk);
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_drain: valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_req(1'b0, ENC_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        bus.req_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'hFE20_8EE3 || bus.out_last !== 1'b1) begin
            n_fail++; $display("[TB] FAIL beq_word: valid %b got %h last %b want fe208ee3 last 1", bus.out_valid, bus.out_instruction, bus.out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_li();
        logic [31:0] imms [3];
        logic [4:0]  rds  [3];
        logic [31:0] w0   [3];
        logic [31:0] w1   [3];
        int          nw   [3];
        imms = '{32'h1234_5678, 32'h0000_0800, 32'h0000_1000};
        rds  = '{5'd5, 5'd1, 5'd1};
        w0   = '{32'h1234_52B7, 32'h0000_10B7, 32'h0000_10B7};
        w1   = '{32'h6782_8293, 32'h8000_8093, 32'h0};
        nw   = '{2, 2, 1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_req(1'b1, encoding_type'(3'($urandom_range(0, 5))), 7'($urandom), 3'($urandom),
                    7'($urandom), rds[i], 5'($urandom), 5'($urandom), imms[i]);
            bus.req_valid = 1'b1;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.req_valid = 1'b0;
            #2;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instruction !== w0[i] || bus.out_last !== (nw[i] == 1)) begin
                n_fail++; $display("[TB] FAIL li%0d_first: valid %b got %h last %b want %h last %b", i, bus.out_valid, bus.out_instruction, bus.out_last, w0[i], nw[i] == 1);
            end
            if (nw[i] == 2) begin
                n_checks++;
                if (bus.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL li%0d_ready_gap: got %b want 0", i, bus.req_ready); end
                @(negedge clk);
                #2;
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instruction !== w1[i] || bus.out_last !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL li%0d_second: valid %b got %h last %b want %h last 1", i, bus.out_valid, bus.out_instruction, bus.out_last, w1[i]);
                end
            end
            @(negedge clk);
            #2;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL li%0d_drain: valid %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        set_req(1'b1, ENC_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        bus.req_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        set_req(1'b0, ENC_I, 7'h13, 3'd0, 7'd0, 5'd3, 5'd3, 5'd0, 32'h0000_0001);
        for (int k = 0; k < 5; k++) begin
            #2;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instruction !== 32'h1234_52B7 || bus.out_last !== 1'b0 || bus.req_ready !== 1'b0) begin
                n_fail++; $display("[TB] FAIL stall_hold%0d: valid %b got %h last %b ready %b want 1 123452b7 0 0", k, bus.out_valid, bus.out_instruction, bus.out_last, bus.req_ready);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #2;
        n_checks++;
        if (bus.out_instruction !== 32'h6782_8293 || bus.out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_second: got %h last %b want 67828293 last 1", bus.out_instruction, bus.out_last); end
        @(negedge clk);
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_no_extra: valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_li();
        @(negedge clk);
        set_req(1'b1, ENC_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        bus.req_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_first: valid %b want 1", bus.out_valid); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instruction !== 32'h0 || bus.out_last !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midrst_clear: valid %b got %h last %b want 0", bus.out_valid, bus.out_instruction, bus.out_last);
        end
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ghost%0d: valid %b got %h want no word", k, bus.out_valid, bus.out_instruction); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [6];
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            f3  = 3'($urandom);
            set_req(1'b0, ENC_I, 7'h13, f3, 7'd0, rd, rs1, 5'd0, imm);
            exp_w[i] = model_word(ENC_I, 7'h13, f3, 7'd0, rd, rs1, 5'd0, imm);
            bus.req_valid = 1'b1;
            #2;
            n_checks++;
            if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, bus.req_ready); end
            if (i > 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instruction !== exp_w[i-1]) begin
                    n_fail++; $display("[TB] FAIL b2b_word%0d: valid %b got %h want %h", i - 1, bus.out_valid, bus.out_instruction, exp_w[i-1]);
                end
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instruction !== exp_w[5]) begin n_fail++; $display("[TB] FAIL b2b_word5: valid %b got %h want %h", bus.out_valid, bus.out_instruction, exp_w[5]); end
        @(negedge clk);
    endtask

    task automatic test_range();
        logic [31:0] imms [2];
        logic [31:0] words [2];
        logic        errs [2];
        imms  = '{32'h0000_0800, 32'h0000_07FF};
        words = '{32'h8000_0093, 32'h7FF0_0093};
`ifdef IMM_RANGE_CHECK_EN
        errs  = '{1'b1, 1'b0};
`else
        errs  = '{1'b0, 1'b0};
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_req(1'b0, ENC_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, imms[i]);
            bus.req_valid = 1'b1;
            @(negedge clk);
            bus.req_valid = 1'b0;
            #2;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instruction !== words[i] || bus.out_err !== errs[i]) begin
                n_fail++; $display("[TB] FAIL range%0d: valid %b got %h err %b want %h err %b", i, bus.out_valid, bus.out_instruction, bus.out_err, words[i], errs[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int n_req);
        int          sent;
        int          cycles;
        logic        pending;
        logic        stalled;
        logic [31:0] held_word;
        logic        li;
        logic [31:0] imm;
        encoding_type enc;
        exp_t        e;
        sent    = 0;
        cycles  = 0;
        pending = 1'b0;
        stalled = 1'b0;
        held_word = 32'h0;
        exp_q.delete();
        while ((sent < n_req || pending || exp_q.size() > 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pending && sent < n_req) begin
                li  = ($urandom_range(0, 3) == 0);
                enc = encoding_type'(3'($urandom_range(0, 5)));
                case ($urandom_range(0, 3))
                    0: imm = $urandom;
                    1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                    2: imm = $urandom & 32'hFFFF_F000;
                    default: case ($urandom_range(0, 7))
                        0: imm = 32'h0000_07FF;  1: imm = 32'h0000_0800;
                        2: imm = 32'hFFFF_F800;  3: imm = 32'hFFFF_F7FF;
                        4: imm = 32'h0000_0FFF;  5: imm = 32'h0000_1000;
                        6: imm = 32'h7FFF_F800;  default: imm = 32'h8000_0000;
                    endcase
                endcase
                set_req(li, enc, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                        5'($urandom), 5'($urandom), imm);
                bus.req_valid = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                bus.req_valid = 1'b0;
            end
            #2;
            if (stalled) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instruction !== held_word) begin
                    n_fail++; $display("[TB] FAIL rand_hold: valid %b got %h want %h", bus.out_valid, bus.out_instruction, held_word);
                end
            end
            stalled   = bus.out_valid && !bus.out_ready;
            held_word = bus.out_instruction;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL rand_unexpected: got %h want no word", bus.out_instruction);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_instruction !== e.word || bus.out_last !== e.last || bus.out_err !== e.err) begin
                        n_fail++; $display("[TB] FAIL rand_word: got %h last %b err %b want %h last %b err %b", bus.out_instruction, bus.out_last, bus.out_err, e.word, e.last, e.err);
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                model_push(bus.req_li, bus.req_encoding, bus.req_opcode, bus.req_funct3, bus.req_funct7,
                           bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
                pending = 1'b0;
                sent++;
            end
        end
        bus.req_valid = 1'b0;
        if (cycles >= 20000) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL rand_timeout: sent %0d of %0d, %0d words outstanding", sent, n_req, exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_addi();
        test_branch();
        test_li();
        test_stall();
        test_reset_mid_li();
        test_back_to_back();
        test_range();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
